// File: rtl/rng_range_sampler_pkg.sv
// Shared types and helpers for the range sampler: FSM states and the
// bit-smear used to build the rejection mask from N-1.
package rng_pkg;

  localparam int RNG_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, CALC, RUN} state_t;

  // Cascaded smear: every bit below the highest set bit ends up set.
  function automatic logic [RNG_WIDTH-1:0] smear_mask(input logic [RNG_WIDTH-1:0] x);
    logic [RNG_WIDTH-1:0] m;
    m = x;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/rng_range_sampler_fifo.sv
// Small synchronous FIFO with first-word fall-through head; push while full
// is accepted only when a pop happens in the same cycle.
module rng_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rng_range_sampler.sv
// Maps raw uniform words onto [0, N-1] by mask-and-reject (no modulo bias),
// buffering accepted samples in a FIFO behind a valid/ready stream.
module rng_range_sampler
  import rng_pkg::*;
#(
  parameter int WIDTH      = RNG_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rnd_in,
  input  logic             rnd_valid,
  input  logic [WIDTH-1:0] cfg_range,
  input  logic             cfg_load,
  output logic             cfg_busy,
  output logic             range_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] reject_cnt
);

  state_t           state;
  logic [WIDTH-1:0] range_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cand;
  logic             cand_ok;
  logic             can_accept;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign cand       = rnd_in & mask_q;
  assign cand_ok    = (cand < range_q);
  assign pop        = out_ready && !cfg_load;
  assign can_accept = !fifo_full || (out_valid && out_ready);
  assign push       = (state == RUN) && rnd_valid && cand_ok && can_accept && !cfg_load;
  assign cfg_busy   = (state == CALC);
  assign out_valid  = !fifo_empty;

  // A load always wins: it restarts the sampler regardless of current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      range_q    <= '0;
      mask_q     <= '0;
      range_err  <= 1'b0;
      reject_cnt <= '0;
    end else if (cfg_load) begin
      reject_cnt <= '0;
      if (cfg_range == '0) begin
        range_err <= 1'b1;
        state     <= IDLE;
      end else begin
        range_q   <= cfg_range;
        range_err <= 1'b0;
        state     <= CALC;
      end
    end else begin
      case (state)
        CALC: begin
          mask_q <= WIDTH'(smear_mask(RNG_WIDTH'(range_q - 1'b1)));
          state  <= RUN;
        end
        RUN: begin
          if (rnd_valid && !cand_ok) reject_cnt <= sat_inc(reject_cnt);
        end
        default: state <= IDLE;
      endcase
    end
  end

  rng_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (cfg_load),
    .push  (push),
    .pop   (pop),
    .din   (cand),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_rng_range_sampler.sv
// Directed bench for the range sampler; expected values are hand-derived.
module tb_rng_range_sampler;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] rnd_in;
  logic             rnd_valid;
  logic [WIDTH-1:0] cfg_range;
  logic             cfg_load;
  logic             cfg_busy;
  logic             range_err;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] reject_cnt;

  int checks = 0;
  int errors = 0;

  rng_range_sampler #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rnd_in     (rnd_in),
    .rnd_valid  (rnd_valid),
    .cfg_range  (cfg_range),
    .cfg_load   (cfg_load),
    .cfg_busy   (cfg_busy),
    .range_err  (range_err),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] n);
    rnd_valid = 1'b0;
    cfg_range = n;
    cfg_load  = 1'b1;
    tick();
    cfg_load  = 1'b0;
  endtask

  task automatic feed(input logic [WIDTH-1:0] w);
    rnd_in    = w;
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] fill17 [5];
  logic [WIDTH-1:0] exp17  [4];

  initial begin
    rst = 1'b1; rnd_in = '0; rnd_valid = 1'b0; cfg_range = '0;
    cfg_load = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    check("rst_err", 32'(range_err), 32'd0);
    check("rst_rej", 32'(reject_cnt), 32'd0);

    // N=10: one CALC cycle, mask 0xF, 0x12345678 -> 8 next cycle
    load(32'd10);
    check("n10_busy_on", 32'(cfg_busy), 32'd1);
    tick();
    check("n10_busy_off", 32'(cfg_busy), 32'd0);
    feed(32'h12345678);
    check("n10_valid", 32'(out_valid), 32'd1);
    check("n10_data", out_data, 32'd8);
    check("n10_rej0", 32'(reject_cnt), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("n10_drain", 32'(out_valid), 32'd0);

    // Two rejections
    feed(32'hDEADBEEF);
    feed(32'h0000000C);
    check("rej_cnt2", 32'(reject_cnt), 32'd2);
    check("rej_novalid", 32'(out_valid), 32'd0);

    // N=0: error, nothing produced
    load(32'd0);
    check("n0_err", 32'(range_err), 32'd1);
    check("n0_busy", 32'(cfg_busy), 32'd0);
    check("n0_rej_clr", 32'(reject_cnt), 32'd0);
    rnd_in = 32'h3; rnd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("n0_idle_valid", 32'(out_valid), 32'd0);
    end
    rnd_valid = 1'b0;

    // N=16: power of two, no rejections, streaming through
    load(32'd16);
    check("n16_err_clr", 32'(range_err), 32'd0);
    check("n16_busy", 32'(cfg_busy), 32'd1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = 32'h9E3779B9 * 32'(i + 1);
      feed(w);
      check("n16_valid", 32'(out_valid), 32'd1);
      check("n16_data", out_data, w & 32'hF);
    end
    check("n16_rej0", 32'(reject_cnt), 32'd0);
    tick();
    check("n16_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // N=1: every valid cycle pushes 0, FIFO caps at 4
    load(32'd1);
    tick();
    rnd_in = 32'hFFFFFFFF; rnd_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rnd_valid = 1'b0;
    check("n1_rej0", 32'(reject_cnt), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("n1_pop_valid", 32'(out_valid), 32'd1);
      check("n1_pop_data", out_data, 32'd0);
      tick();
    end
    check("n1_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // N=17: fill, then simultaneous pop and push while full
    fill17[0] = 32'h00000003; fill17[1] = 32'hFFFFFFF0; fill17[2] = 32'h0000001F;
    fill17[3] = 32'h00000007; fill17[4] = 32'h20000001;
    exp17[0] = 32'd16; exp17[1] = 32'd7; exp17[2] = 32'd1; exp17[3] = 32'd5;
    load(32'd17);
    tick();
    for (int i = 0; i < 5; i++) feed(fill17[i]);
    check("n17_rej1", 32'(reject_cnt), 32'd1);
    check("n17_head", out_data, 32'd3);
    out_ready = 1'b1;
    feed(32'h00000005);
    for (int i = 0; i < 4; i++) begin
      check("n17_order_valid", 32'(out_valid), 32'd1);
      check("n17_order_data", out_data, exp17[i]);
      tick();
    end
    check("n17_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Mid-stream reset
    load(32'd10);
    tick();
    for (int i = 0; i < 7; i++) feed(32'h0000000F);
    feed(32'd1); feed(32'd2); feed(32'd3);
    check("mid_rej7", 32'(reject_cnt), 32'd7);
    check("mid_head", out_data, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_rej", 32'(reject_cnt), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_busy", 32'(cfg_busy), 32'd0);
    feed(32'd1);
    check("mid_rst_idle", 32'(out_valid), 32'd0);

    // Same again, but restarted by a load (with a pop request pending)
    load(32'd10);
    tick();
    for (int i = 0; i < 7; i++) feed(32'h0000000F);
    feed(32'd1); feed(32'd2); feed(32'd3);
    check("mid2_rej7", 32'(reject_cnt), 32'd7);
    out_ready = 1'b1;
    load(32'd10);
    out_ready = 1'b0;
    check("reload_valid", 32'(out_valid), 32'd0);
    check("reload_rej", 32'(reject_cnt), 32'd0);
    check("reload_busy", 32'(cfg_busy), 32'd1);
    tick();

    // Counter saturates at all-ones
    for (int i = 0; i < 20; i++) feed(32'hFFFFFFFF);
    check("sat_rej", 32'(reject_cnt), 32'd15);
    check("sat_novalid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rng_range_sampler.md
Name: rng_range_sampler

Overview:
- Downstream consumer of the taus113 32-bit uniform generator.
- Maps each raw word onto the range [0, range-1] by mask-and-reject sampling, so the result has no modulo bias.
- Accepted samples are buffered in a small FIFO and presented on a valid/ready stream to stochastic consumers.
- Exposes a saturating rejection counter for efficiency monitoring.

Parameters:
- WIDTH, 32: width of raw random word, range and output sample.
- FIFO_DEPTH, 4: number of accepted-sample entries; power of two, at least 2.
- CNT_W, 16: width of the rejection counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rnd_in  in  WIDTH  raw word from the generator; a new value each cycle.
- rnd_valid  in  1  rnd_in is usable this cycle; low during generator reseed.
- cfg_range  in  WIDTH  requested range size N.
- cfg_load  in  1  one-cycle pulse; latches cfg_range.
- cfg_busy  out  1  high while the mask is being computed.
- range_err  out  1  sticky; set when N=0 is loaded, cleared by the next valid load.
- out_data  out  WIDTH  sample in [0, N-1]; FIFO head, first-word fall-through.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid and out_ready are both high.
- reject_cnt  out  CNT_W  rejected candidates since the last load; saturates at all-ones.

Behaviour:
- Reset: state IDLE; FIFO empty; mask=0; range=0. All outputs read 0 (out_data, out_valid, cfg_busy, range_err, reject_cnt).
- State IDLE: no samples are produced and rnd_in is ignored.
  - On cfg_load with N=0: range_err<=1, stay in IDLE.
  - On cfg_load with N>=1: latch N, range_err<=0, go to CALC.
- State CALC, exactly one cycle, cfg_busy=1:
  - mask <= bit-smear of (N-1), i.e. OR of (N-1) shifted right by 1, 2, 4, 8, 16.
  - Go to RUN.
- State RUN: per cycle, cand = rnd_in & mask.
  - If rnd_valid=1 and cand < N and the FIFO can accept: push cand.
  - If rnd_valid=1 and cand >= N: reject_cnt += 1 (saturating); nothing is pushed.
  - If the FIFO cannot accept: a valid candidate is dropped silently and not counted as a rejection.
  - Latency: an accepted rnd_in sampled on edge k is on out_data with out_valid=1 after edge k, i.e. visible in cycle k+1.
- FIFO can accept when count < FIFO_DEPTH, or when count = FIFO_DEPTH and a pop happens in the same cycle (simultaneous push and pop when full is legal). Ordering is strictly FIFO. Pointers wrap modulo FIFO_DEPTH.
- N=1: mask=0, so every valid cycle pushes the value 0.
- N a power of two: mask=N-1 and there are no rejections.
- cfg_load in CALC or RUN:
  - Same-edge effect: FIFO flushed, reject_cnt cleared.
  - Then handled exactly as a load in IDLE (N=0 goes to IDLE with the error set).
  - cfg_load takes priority over a push or pop in the same cycle.
- rst asserted in any state, including mid-stream or in CALC: everything returns to reset values on that edge. A popped-but-unconsumed value is discarded.
- Arithmetic: the compare is unsigned WIDTH-bit. No multipliers or dividers.

Decomposition:
- Package rng_pkg holds:
  - WIDTH default constant;
  - state enum {IDLE, CALC, RUN};
  - pure function smear_mask(WIDTH-bit) -> WIDTH-bit.
- Sub-module rng_sync_fifo holds parameterised storage, read/write pointers and count, and exposes full, empty, push and pop.
- The sampler holds the FSM, candidate check and counter.

Test Plan:
- Reset, then load N=10: cfg_busy high for exactly 1 cycle, mask=0x0000000F. Then rnd_in=0x12345678 with rnd_valid=1 -> out_data=8 with out_valid=1 on the next cycle. reject_cnt=0.
- N=10, rnd_in=0xDEADBEEF (cand 0xF) then 0x0000000C (cand 0xC) -> both rejected, reject_cnt=2, out_valid stays 0.
- Load N=0 -> range_err=1, out_valid=0 for 10 cycles. Then load N=16 -> range_err=0, mask=0xF, 16 random words in -> 16 pushes with 0 rejects.
- N=1, out_ready=0, 6 valid cycles -> FIFO holds 4 zeros, reject_cnt=0. Then out_ready=1 -> exactly 4 pops, all values 0.
- N=17 (mask 0x1F), FIFO full, out_ready=1, rnd_in=0x00000005 -> simultaneous pop and push. Count stays at 4; 0x5 emerges after the prior entries in order.
- Mid-stream with 3 entries buffered and reject_cnt=7: rst pulsed for 1 cycle -> out_valid=0, reject_cnt=0, state IDLE. A repeat of the run with cfg_load instead of rst -> FIFO empty, reject_cnt=0, cfg_busy=1 on the next cycle.
